id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline, sitting directly upstream of the ALU.
- Latches decoded operands and control from ID, then drives ALU in1/in2/op_code.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID and inserts a bubble; honours branch flush.

Parameters:
WORD_LEN, 32, datapath width
REG_ADDR, 5, register-index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  REG_ADDR  source register 1 index
id_rt_addr  in  REG_ADDR  source register 2 index
id_rd_addr  in  REG_ADDR  destination index (already muxed rt/rd)
id_rs_data  in  WORD_LEN  register-file read 1
id_rt_data  in  WORD_LEN  register-file read 2
id_imm  in  WORD_LEN  sign-extended immediate
id_alu_src  in  1  1: in2 = immediate
id_alu_op  in  3  ALU op code (add=1, sub=2, and=3, or=4, slt=5)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
flush  in  1  taken branch; kill the ID instruction
exmem_reg_write  in  1  EX/MEM writes back
exmem_rd  in  REG_ADDR  EX/MEM destination
exmem_result  in  WORD_LEN  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes back
memwb_rd  in  REG_ADDR  MEM/WB destination
memwb_data  in  WORD_LEN  MEM/WB write-back value
stall  out  1  hold PC and IF/ID (combinational)
alu_in1, alu_in2  out  WORD_LEN  forwarded ALU operands
alu_op  out  3  registered op code
ex_store_data  out  WORD_LEN  forwarded rt value for stores
ex_rd  out  REG_ADDR  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control

Behaviour:
- Register update, each cycle:
  - rst: registers cleared, alu_op = 1 (add), so the ALU never sees an undefined op.
  - else if flush or stall: bubble loaded (ex_valid = 0, all write/mem controls = 0, alu_op = 1, data = 0, ex_rd = 0).
  - else: all id_* captured; control bits gated with id_valid.
- Latency: 1 cycle ID to EX outputs. Forwarding muxes are combinational on the registered operands.
- Load-use hazard:
  - hz = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs_addr | ex_rd == id_rt_addr).
  - rt is always treated as used.
- stall = hz & ~flush. Flush takes priority; the killed instruction needs no stall.
- Stall lasts exactly one cycle: the next cycle ex_valid = 0, so hz drops.
- Forwarding for rs (rt identical):
  - exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs gives exmem_result.
  - else memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs gives memwb_data.
  - else the registered register-file data.
  - EX/MEM wins over MEM/WB. r0 is never forwarded.
- Operand selection:
  - alu_in1 = forwarded rs.
  - alu_in2 = registered imm when alu_src = 1, else forwarded rt.
  - ex_store_data = forwarded rt, independent of alu_src.
- Write-back and read of the same register in one cycle: the register file writes first half / reads second half, so no forwarding is needed from beyond MEM/WB.
- Reset mid-stall: rst dominates; stall = 0 the cycle after reset.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - Forwarding muxes are removed; operands come straight from the registers.
  - stall = ~flush & id_valid & (source match against ex_rd with ex_reg_write, or against exmem_rd with exmem_reg_write), ignoring r0.
  - This may stall up to 2 cycles.
  - A bubble is inserted each stalled cycle.

Decomposition:
- Shared include alu_defs.vh holds the op-code constants (add/sub/and/or/slt = 1..5) and the bubble op constant.
- One sub-module, forwarding_unit: the combinational 3-way select, instantiated twice (rs, rt).
- Hazard logic and the register stay in id_ex_stage.

Test Plan:
- Reset: rst = 1 for 2 cycles, then 0 -> all ex_* = 0, alu_op = 1, stall = 0.
- EX/MEM forward: EX/MEM rd = 8, result 0x10, write = 1; ID add rs = 8 rt = 9 with regfile 0/5 -> next cycle alu_in1 = 0x10, alu_in2 = 5.
- Priority: EX/MEM rd = 8 = 0x10 and MEM/WB rd = 8 = 0x20 -> alu_in1 = 0x10. With exmem_rd = 0 and memwb_rd = 0 both writing -> no forward, register value used.
- Load-use: EX holds lw rd = 4; ID has rs = 4 -> stall = 1 for one cycle, bubble has ex_reg_write = 0. The instruction issues the next cycle and memwb forwarding supplies the loaded value.
- Flush with hazard: load-use condition plus flush = 1 -> stall = 0, bubble loaded, ID instruction discarded.
- Immediate/store: sw with alu_src = 1, imm = 0xFFFFFFFC, rt forwarded from MEM/WB = 0xAB -> alu_in2 = 0xFFFFFFFC, ex_store_data = 0xAB.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register: default datapath
// widths, ALU op-code constants and the op code loaded with a bubble.
// No ports (package).
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int WORD_LEN_DEF = 32;
    localparam int REG_ADDR_DEF = 5;

    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SLT  = 3'd5
    } alu_op_e;

    // A bubble (and reset) drives add so the ALU never sees an undefined op.
    localparam logic [2:0] ALU_BUBBLE_OP = 3'(ALU_ADD);

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every ID/EX signal except clk/rst.
//   master : the surroundings (ID stage, EX/MEM and MEM/WB registers, ALU)
//   slave  : the id_ex_stage block
// Groups: id_* (decoded instruction from ID), flush, exmem_* / memwb_*
// (write-back sources for forwarding), stall (hold PC and IF/ID),
// alu_* / ex_* (registered and forwarded EX-stage outputs).
//
// Handshake: id_valid qualifies the ID instruction. stall is a hold
// request back to IF/ID: while stall is high the ID instruction is not
// consumed and ID must present it again next cycle; a bubble enters EX
// instead. flush kills the ID instruction regardless of stall.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int WORD_LEN = 32,
    parameter int REG_ADDR = 5
);
    logic                id_valid;
    logic [REG_ADDR-1:0] id_rs_addr;
    logic [REG_ADDR-1:0] id_rt_addr;
    logic [REG_ADDR-1:0] id_rd_addr;
    logic [WORD_LEN-1:0] id_rs_data;
    logic [WORD_LEN-1:0] id_rt_data;
    logic [WORD_LEN-1:0] id_imm;
    logic                id_alu_src;
    logic [2:0]          id_alu_op;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                flush;
    logic                exmem_reg_write;
    logic [REG_ADDR-1:0] exmem_rd;
    logic [WORD_LEN-1:0] exmem_result;
    logic                memwb_reg_write;
    logic [REG_ADDR-1:0] memwb_rd;
    logic [WORD_LEN-1:0] memwb_data;
    logic                stall;
    logic [WORD_LEN-1:0] alu_in1;
    logic [WORD_LEN-1:0] alu_in2;
    logic [2:0]          alu_op;
    logic [WORD_LEN-1:0] ex_store_data;
    logic [REG_ADDR-1:0] ex_rd;
    logic                ex_valid;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_alu_op, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        input  stall, alu_in1, alu_in2, alu_op, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_alu_op, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        output stall, alu_in1, alu_in2, alu_op, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage_forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational 3-way operand select for one source register.
//   src_addr        : source register index held in EX
//   reg_data        : register-file value captured in ID/EX
//   exmem_*         : EX/MEM write-back (highest priority, newest value)
//   memwb_*         : MEM/WB write-back
//   data_out        : operand delivered to the ALU
// r0 is never forwarded. Results older than MEM/WB need no path because
// the register file writes in the first half-cycle and reads in the second.
// ---------------------------------------------------------------------------
module forwarding_unit #(
    parameter int WORD_LEN = 32,
    parameter int REG_ADDR = 5
) (
    input  logic [REG_ADDR-1:0] src_addr,
    input  logic [WORD_LEN-1:0] reg_data,
    input  logic                exmem_reg_write,
    input  logic [REG_ADDR-1:0] exmem_rd,
    input  logic [WORD_LEN-1:0] exmem_result,
    input  logic                memwb_reg_write,
    input  logic [REG_ADDR-1:0] memwb_rd,
    input  logic [WORD_LEN-1:0] memwb_data,
    output logic [WORD_LEN-1:0] data_out
);

    always_comb begin
        data_out = reg_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_addr)) begin
            data_out = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_addr)) begin
            data_out = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS pipeline, feeding the ALU.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : id_ex_stage_if.slave (ID inputs, flush, EX/MEM and MEM/WB
//          write-back sources, stall, ALU operands and EX controls)
// Build option EX_FORWARD_EN:
//   defined   : operands forwarded from EX/MEM and MEM/WB; only a
//               load-use dependency stalls (one cycle).
//   undefined : no forwarding; any dependency on the instruction in EX or
//               in EX/MEM stalls (up to two cycles), a bubble per cycle.
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int REG_ADDR = REG_ADDR_DEF
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    logic                ex_valid_q;
    logic                ex_reg_write_q;
    logic                ex_mem_read_q;
    logic                ex_mem_write_q;
    logic                ex_mem_to_reg_q;
    logic                ex_alu_src_q;
    logic [2:0]          ex_alu_op_q;
    logic [REG_ADDR-1:0] ex_rd_q;
    logic [REG_ADDR-1:0] ex_rs_q;
    logic [REG_ADDR-1:0] ex_rt_q;
    logic [WORD_LEN-1:0] ex_rs_data_q;
    logic [WORD_LEN-1:0] ex_rt_data_q;
    logic [WORD_LEN-1:0] ex_imm_q;

    logic                stall;
    logic                fwd_en;
    logic [WORD_LEN-1:0] rs_fwd;
    logic [WORD_LEN-1:0] rt_fwd;

    // rt is treated as a source for every instruction; a false match only
    // costs a cycle, never correctness.
    logic id_uses_ex_rd;
    logic id_uses_exmem_rd;

    assign id_uses_ex_rd    = (ex_rd_q != '0) &&
                              ((ex_rd_q == bus.id_rs_addr) || (ex_rd_q == bus.id_rt_addr));
    assign id_uses_exmem_rd = (bus.exmem_rd != '0) &&
                              ((bus.exmem_rd == bus.id_rs_addr) || (bus.exmem_rd == bus.id_rt_addr));

`ifdef EX_FORWARD_EN
    assign fwd_en = 1'b1;
    // Only a load in EX cannot be forwarded in time; flush wins because the
    // killed instruction has nothing to wait for.
    assign stall  = ex_valid_q && ex_mem_read_q && bus.id_valid && id_uses_ex_rd &&
                    !bus.flush;
`else
    // With the write enables tied low the forwarding muxes collapse to the
    // registered register-file data.
    assign fwd_en = 1'b0;
    assign stall  = !bus.flush && bus.id_valid &&
                    ((ex_reg_write_q && id_uses_ex_rd) ||
                     (bus.exmem_reg_write && id_uses_exmem_rd));
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.flush || stall) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_alu_op_q     <= ALU_BUBBLE_OP;
            ex_rd_q         <= '0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_imm_q        <= '0;
        end else begin
            ex_valid_q      <= bus.id_valid;
            ex_reg_write_q  <= bus.id_valid && bus.id_reg_write;
            ex_mem_read_q   <= bus.id_valid && bus.id_mem_read;
            ex_mem_write_q  <= bus.id_valid && bus.id_mem_write;
            ex_mem_to_reg_q <= bus.id_valid && bus.id_mem_to_reg;
            ex_alu_src_q    <= bus.id_alu_src;
            ex_alu_op_q     <= bus.id_alu_op;
            ex_rd_q         <= bus.id_rd_addr;
            ex_rs_q         <= bus.id_rs_addr;
            ex_rt_q         <= bus.id_rt_addr;
            ex_rs_data_q    <= bus.id_rs_data;
            ex_rt_data_q    <= bus.id_rt_data;
            ex_imm_q        <= bus.id_imm;
        end
    end

    forwarding_unit #(.WORD_LEN(WORD_LEN), .REG_ADDR(REG_ADDR)) u_fwd_rs (
        .src_addr        (ex_rs_q),
        .reg_data        (ex_rs_data_q),
        .exmem_reg_write (fwd_en && bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (fwd_en && bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_data      (bus.memwb_data),
        .data_out        (rs_fwd)
    );

    forwarding_unit #(.WORD_LEN(WORD_LEN), .REG_ADDR(REG_ADDR)) u_fwd_rt (
        .src_addr        (ex_rt_q),
        .reg_data        (ex_rt_data_q),
        .exmem_reg_write (fwd_en && bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (fwd_en && bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_data      (bus.memwb_data),
        .data_out        (rt_fwd)
    );

    assign bus.stall         = stall;
    assign bus.alu_in1       = rs_fwd;
    assign bus.alu_in2       = ex_alu_src_q ? ex_imm_q : rt_fwd;
    assign bus.alu_op        = ex_alu_op_q;
    assign bus.ex_store_data = rt_fwd;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.ex_mem_to_reg = ex_mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: reset check, a table of directed
// cycles (forwarding, priority, r0, load-use, flush, store), a reset-during-
// stall sequence, and randomized cycles checked against a reference model.
// Follows EX_FORWARD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- records ----------------
    typedef struct packed {
        logic        id_valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic [2:0]  op;
        logic        rw, mr, mw, m2r;
        logic        flush;
        logic        xm_rw;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] mw_data;
    } in_t;

    typedef struct packed {
        logic        stall, valid, rw, mr, mw, m2r;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] in1, in2, st;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    // Instruction currently sitting in EX, as the reference model sees it.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, alu_src;
        logic [2:0]  op;
        logic [4:0]  rd, rs, rt;
        logic [31:0] rs_data, rt_data, imm;
    } ex_t;

    vec_t tbl[$];
    ex_t  m;
    int   n_checks = 0;
    int   n_errors = 0;

    // ---------------- reference model ----------------
    function automatic ex_t bubble();
        ex_t b;
        b = '0;
        b.op = 3'd1;
        return b;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] v, input in_t i);
`ifdef EX_FORWARD_EN
        if (i.xm_rw && a != 0 && a == i.xm_rd) return i.xm_res;
        if (i.mw_rw && a != 0 && a == i.mw_rd) return i.mw_data;
`endif
        return v;
    endfunction

    function automatic logic reads(input logic [4:0] r, input in_t i);
        return (r != 0) && (r == i.rs || r == i.rt);
    endfunction

    function automatic logic model_stall(input in_t i);
        if (i.flush || !i.id_valid) return 1'b0;
`ifdef EX_FORWARD_EN
        return m.valid && m.mr && reads(m.rd, i);
`else
        return (m.rw && reads(m.rd, i)) || (i.xm_rw && reads(i.xm_rd, i));
`endif
    endfunction

    function automatic out_t model_out(input in_t i);
        out_t o;
        o.stall = model_stall(i);
        o.valid = m.valid;
        o.rw    = m.rw;
        o.mr    = m.mr;
        o.mw    = m.mw;
        o.m2r   = m.m2r;
        o.op    = m.op;
        o.rd    = m.rd;
        o.in1   = operand(m.rs, m.rs_data, i);
        o.in2   = m.alu_src ? m.imm : operand(m.rt, m.rt_data, i);
        o.st    = operand(m.rt, m.rt_data, i);
        return o;
    endfunction

    task automatic model_step(input in_t i, input logic r);
        if (r || i.flush || model_stall(i)) begin
            m = bubble();
        end else begin
            m.valid   = i.id_valid;
            m.rw      = i.id_valid & i.rw;
            m.mr      = i.id_valid & i.mr;
            m.mw      = i.id_valid & i.mw;
            m.m2r     = i.id_valid & i.m2r;
            m.alu_src = i.alu_src;
            m.op      = i.op;
            m.rd      = i.rd;
            m.rs      = i.rs;
            m.rt      = i.rt;
            m.rs_data = i.rs_data;
            m.rt_data = i.rt_data;
            m.imm     = i.imm;
        end
    endtask

    // ---------------- driver / sampler ----------------
    task automatic drive(input in_t i);
        bus.id_valid        = i.id_valid;
        bus.id_rs_addr      = i.rs;
        bus.id_rt_addr      = i.rt;
        bus.id_rd_addr      = i.rd;
        bus.id_rs_data      = i.rs_data;
        bus.id_rt_data      = i.rt_data;
        bus.id_imm          = i.imm;
        bus.id_alu_src      = i.alu_src;
        bus.id_alu_op       = i.op;
        bus.id_reg_write    = i.rw;
        bus.id_mem_read     = i.mr;
        bus.id_mem_write    = i.mw;
        bus.id_mem_to_reg   = i.m2r;
        bus.flush           = i.flush;
        bus.exmem_reg_write = i.xm_rw;
        bus.exmem_rd        = i.xm_rd;
        bus.exmem_result    = i.xm_res;
        bus.memwb_reg_write = i.mw_rw;
        bus.memwb_rd        = i.mw_rd;
        bus.memwb_data      = i.mw_data;
    endtask

    function automatic out_t sample();
        out_t o;
        o.stall = bus.stall;
        o.valid = bus.ex_valid;
        o.rw    = bus.ex_reg_write;
        o.mr    = bus.ex_mem_read;
        o.mw    = bus.ex_mem_write;
        o.m2r   = bus.ex_mem_to_reg;
        o.op    = bus.alu_op;
        o.rd    = bus.ex_rd;
        o.in1   = bus.alu_in1;
        o.in2   = bus.alu_in2;
        o.st    = bus.ex_store_data;
        return o;
    endfunction

    // One clock cycle: inputs applied after the falling edge, outputs
    // sampled 1 ns later, model advanced on the rising edge.
    task automatic cycle(input in_t i, input logic r, output out_t got, output out_t pred);
        @(negedge clk);
        rst = r;
        drive(i);
        #1;
        got  = sample();
        pred = model_out(i);
        @(posedge clk);
        model_step(i, r);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input out_t got, input out_t exp);
        chk($sformatf("%s.stall", tag),         32'(got.stall), 32'(exp.stall));
        chk($sformatf("%s.ex_valid", tag),      32'(got.valid), 32'(exp.valid));
        chk($sformatf("%s.ex_reg_write", tag),  32'(got.rw),    32'(exp.rw));
        chk($sformatf("%s.ex_mem_read", tag),   32'(got.mr),    32'(exp.mr));
        chk($sformatf("%s.ex_mem_write", tag),  32'(got.mw),    32'(exp.mw));
        chk($sformatf("%s.ex_mem_to_reg", tag), 32'(got.m2r),   32'(exp.m2r));
        chk($sformatf("%s.alu_op", tag),        32'(got.op),    32'(exp.op));
        chk($sformatf("%s.ex_rd", tag),         32'(got.rd),    32'(exp.rd));
        chk($sformatf("%s.alu_in1", tag),       got.in1,        exp.in1);
        chk($sformatf("%s.alu_in2", tag),       got.in2,        exp.in2);
        chk($sformatf("%s.ex_store_data", tag), got.st,         exp.st);
    endtask

    // ---------------- table helpers ----------------
    function automatic in_t idle_in();
        in_t i;
        i = '0;
        i.op = 3'd1;
        return i;
    endfunction

    function automatic out_t exp_idle();
        out_t e;
        e = '0;
        e.op = 3'd1;
        return e;
    endfunction

    function automatic in_t instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] rsd, input logic [31:0] rtd, input logic [2:0] op);
        in_t i;
        i = idle_in();
        i.id_valid = 1'b1;
        i.rs = rs; i.rt = rt; i.rd = rd;
        i.rs_data = rsd; i.rt_data = rtd;
        i.op = op;
        i.rw = 1'b1;
        return i;
    endfunction

    function automatic in_t load_r4();
        in_t i;
        i = instr(5'd1, 5'd4, 5'd4, 32'h1000, 32'h0, 3'd1);
        i.imm = 32'd8; i.alu_src = 1'b1; i.mr = 1'b1; i.m2r = 1'b1;
        return i;
    endfunction

    task automatic add_row(input in_t i, input out_t e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        tbl.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        in_t  i;
        out_t e;
        out_t got;
        out_t pred;
        in_t  dep;

        m = bubble();
        drive(idle_in());

        // Reset held for two edges, then released.
        cycle(idle_in(), 1'b1, got, pred);
        cycle(idle_in(), 1'b1, got, pred);
        cycle(idle_in(), 1'b0, got, pred);
        compare("reset", got, exp_idle());

        // Row 0/1: EX/MEM forward to rs.
        add_row(instr(5'd8, 5'd9, 5'd10, 32'h0, 32'h5, 3'd1), exp_idle());
        i = idle_in(); i.xm_rw = 1; i.xm_rd = 5'd8; i.xm_res = 32'h10;
        e = exp_idle(); e.valid = 1; e.rw = 1; e.rd = 5'd10; e.in2 = 32'h5; e.st = 32'h5;
`ifdef EX_FORWARD_EN
        e.in1 = 32'h10;
`else
        e.in1 = 32'h0;
`endif
        add_row(i, e);

        // Row 2/3: EX/MEM wins over MEM/WB.
        add_row(instr(5'd8, 5'd0, 5'd11, 32'h99, 32'h0, 3'd1), exp_idle());
        i = idle_in(); i.xm_rw = 1; i.xm_rd = 5'd8; i.xm_res = 32'h10;
        i.mw_rw = 1; i.mw_rd = 5'd8; i.mw_data = 32'h20;
        e = exp_idle(); e.valid = 1; e.rw = 1; e.rd = 5'd11;
`ifdef EX_FORWARD_EN
        e.in1 = 32'h10;
`else
        e.in1 = 32'h99;
`endif
        add_row(i, e);

        // Row 4/5: writers to r0 are never forwarded.
        add_row(instr(5'd0, 5'd0, 5'd12, 32'h33, 32'h44, 3'd2), exp_idle());
        i = idle_in(); i.xm_rw = 1; i.xm_rd = 5'd0; i.xm_res = 32'h10;
        i.mw_rw = 1; i.mw_rd = 5'd0; i.mw_data = 32'h20;
        e = exp_idle(); e.valid = 1; e.rw = 1; e.op = 3'd2; e.rd = 5'd12;
        e.in1 = 32'h33; e.in2 = 32'h44; e.st = 32'h44;
        add_row(i, e);

        // Rows 6..: load-use on r4.
        dep = instr(5'd4, 5'd2, 5'd5, 32'h0, 32'h7, 3'd1);
        add_row(load_r4(), exp_idle());
        e = exp_idle(); e.stall = 1; e.valid = 1; e.rw = 1; e.mr = 1; e.m2r = 1;
        e.rd = 5'd4; e.in1 = 32'h1000; e.in2 = 32'd8; e.st = 32'h0;
        add_row(dep, e);
        i = dep; i.xm_rw = 1; i.xm_rd = 5'd4; i.xm_res = 32'h1008;
        e = exp_idle();
`ifdef EX_FORWARD_EN
        add_row(i, e);
        i = idle_in(); i.mw_rw = 1; i.mw_rd = 5'd4; i.mw_data = 32'hBEEF;
        e = exp_idle(); e.valid = 1; e.rw = 1; e.rd = 5'd5;
        e.in1 = 32'hBEEF; e.in2 = 32'h7; e.st = 32'h7;
        add_row(i, e);
`else
        e.stall = 1;
        add_row(i, e);
        i = dep; i.rs_data = 32'hBEEF; i.mw_rw = 1; i.mw_rd = 5'd4; i.mw_data = 32'hBEEF;
        add_row(i, exp_idle());
        e = exp_idle(); e.valid = 1; e.rw = 1; e.rd = 5'd5;
        e.in1 = 32'hBEEF; e.in2 = 32'h7; e.st = 32'h7;
        add_row(idle_in(), e);
`endif

        // Load-use plus flush: no stall, dependent instruction discarded.
        add_row(load_r4(), exp_idle());
        i = dep; i.flush = 1;
        e = exp_idle(); e.valid = 1; e.rw = 1; e.mr = 1; e.m2r = 1;
        e.rd = 5'd4; e.in1 = 32'h1000; e.in2 = 32'd8;
        add_row(i, e);
        i = idle_in(); i.xm_rw = 1; i.xm_rd = 5'd4; i.xm_res = 32'h1008;
        add_row(i, exp_idle());

        // Store with immediate: alu_in2 = imm, store data forwarded from MEM/WB.
        i = instr(5'd2, 5'd3, 5'd0, 32'h100, 32'h0, 3'd1);
        i.rw = 0; i.mw = 1; i.alu_src = 1; i.imm = 32'hFFFF_FFFC;
        add_row(i, exp_idle());
        i = idle_in(); i.mw_rw = 1; i.mw_rd = 5'd3; i.mw_data = 32'hAB;
        e = exp_idle(); e.valid = 1; e.mw = 1; e.in1 = 32'h100; e.in2 = 32'hFFFF_FFFC;
`ifdef EX_FORWARD_EN
        e.st = 32'hAB;
`else
        e.st = 32'h0;
`endif
        add_row(i, e);

        foreach (tbl[k]) begin
            cycle(tbl[k].in, 1'b0, got, pred);
            compare($sformatf("row%0d", k), got, tbl[k].exp);
        end

        // Reset asserted while a load-use stall is pending.
        cycle(load_r4(), 1'b0, got, pred);
        cycle(dep, 1'b1, got, pred);
        chk("rst_mid.stall_before", 32'(got.stall), 32'd1);
        cycle(dep, 1'b0, got, pred);
        compare("rst_mid.after", got, exp_idle());

        // Randomized cycles against the reference model.
        for (int n = 0; n < 400; n++) begin
            i.id_valid = ($urandom_range(0, 4) != 0);
            i.rs       = 5'($urandom_range(0, 7));
            i.rt       = 5'($urandom_range(0, 7));
            i.rd       = 5'($urandom_range(0, 7));
            i.rs_data  = $urandom;
            i.rt_data  = $urandom;
            i.imm      = $urandom;
            i.alu_src  = 1'($urandom_range(0, 1));
            i.op       = 3'($urandom_range(1, 5));
            i.rw       = 1'($urandom_range(0, 1));
            i.mr       = ($urandom_range(0, 2) == 0);
            i.mw       = ($urandom_range(0, 3) == 0);
            i.m2r      = 1'($urandom_range(0, 1));
            i.flush    = ($urandom_range(0, 7) == 0);
            i.xm_rw    = 1'($urandom_range(0, 1));
            i.xm_rd    = 5'($urandom_range(0, 7));
            i.xm_res   = $urandom;
            i.mw_rw    = 1'($urandom_range(0, 1));
            i.mw_rd    = 5'($urandom_range(0, 7));
            i.mw_data  = $urandom;
            cycle(i, ($urandom_range(0, 49) == 0), got, pred);
            compare($sformatf("rnd%0d", n), got, pred);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
